// File: rtl/adc_capture_ctrl_pkg.sv
// Shared definitions for the ADC capture controller: FSM state encoding
// and the default widths used by the controller and its sample buffer.
package adc_capture_ctrl_pkg;

  localparam int DEFAULT_DATA_W     = 32;
  localparam int DEFAULT_FIFO_DEPTH = 16;
  localparam int OVS_W              = 10;
  localparam int CNT_W              = 12;
  localparam int DISC_W             = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } capState_e;

endpackage

// File: rtl/adc_capture_ctrl_sample_fifo.sv
// First-word-fall-through sample buffer. A word written on one edge is
// visible at the head right after that edge. A write into a full buffer
// is only taken when a pop frees a slot on the same edge; otherwise it is
// reported on drop_o so the controller can flag an overflow.
module sample_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       rd_ready_i,
  output logic [DATA_W-1:0]          data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       drop_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              full;
  logic              pop;
  logic              push;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign valid_o = (level_q != '0);
  assign pop     = valid_o && rd_ready_i;
  assign push    = wr_en_i && (!full || pop);
  assign drop_o  = wr_en_i && full && !pop;
  assign level_o = level_q;
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  // Storage array; no reset needed since the head is gated by valid_o.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture controller for a VCO ADC: enables the converter, drops a number
// of settling samples, buffers a counted (or continuous) run of samples in
// a FWFT FIFO, and reports completion and overflow.
module adc_capture_ctrl
  import adc_capture_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_in,
  input  logic                          abort_in,
  input  logic [OVS_W-1:0]              cfg_oversample_in,
  input  logic [DISC_W-1:0]             cfg_discard_in,
  input  logic [CNT_W-1:0]              cfg_count_in,
  output logic                          adc_enable_out,
  output logic [OVS_W-1:0]              adc_oversample_out,
  input  logic [DATA_W-1:0]             adc_data_in,
  input  logic                          adc_valid_in,
  output logic [DATA_W-1:0]             data_out,
  output logic                          valid_out,
  input  logic                          ready_in,
  output logic                          busy_out,
  output logic                          done_out,
  output logic                          overflow_out,
  output logic [$clog2(FIFO_DEPTH):0]   level_out
);

  capState_e         state_q;
  logic              enable_q;
  logic [OVS_W-1:0]  ovs_q;
  logic [DISC_W-1:0] disc_cfg_q;
  logic [CNT_W-1:0]  count_cfg_q;
  logic [DISC_W-1:0] disc_cnt_q;
  logic [DISC_W-1:0] disc_cnt_d;
  logic [CNT_W-1:0]  cap_cnt_q;
  logic [CNT_W-1:0]  cap_cnt_d;
  logic              done_q;
  logic              overflow_q;
  logic              fifo_wr;
  logic              fifo_drop;

  assign disc_cnt_d = disc_cnt_q + 1'b1;
  assign cap_cnt_d  = cap_cnt_q + 1'b1;

  // An abort wins over a sample arriving in the same cycle, so the run
  // stops cleanly without one extra word slipping into the buffer.
  assign fifo_wr = (state_q == ST_CAPTURE) && adc_valid_in && !abort_in;

  assign adc_enable_out     = enable_q;
  assign adc_oversample_out = ovs_q;
  assign busy_out           = (state_q != ST_IDLE);
  assign done_out           = done_q;
  assign overflow_out       = overflow_q;

  // Run sequencing: start latches config, settle drops samples, capture
  // counts samples (stored or dropped), done pulses for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      enable_q    <= 1'b0;
      ovs_q       <= '0;
      disc_cfg_q  <= '0;
      count_cfg_q <= '0;
      disc_cnt_q  <= '0;
      cap_cnt_q   <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (fifo_drop) overflow_q <= 1'b1;
      if (abort_in) begin
        state_q  <= ST_IDLE;
        enable_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_in) begin
              ovs_q       <= cfg_oversample_in;
              disc_cfg_q  <= cfg_discard_in;
              count_cfg_q <= cfg_count_in;
              disc_cnt_q  <= '0;
              cap_cnt_q   <= '0;
              overflow_q  <= 1'b0;
              enable_q    <= 1'b1;
              state_q     <= (cfg_discard_in == '0) ? ST_CAPTURE : ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (adc_valid_in) begin
              disc_cnt_q <= disc_cnt_d;
              if (disc_cnt_d == disc_cfg_q) state_q <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            if (adc_valid_in) begin
              cap_cnt_q <= cap_cnt_d;
              if ((count_cfg_q != '0) && (cap_cnt_d == count_cfg_q)) begin
                state_q  <= ST_DONE;
                enable_q <= 1'b0;
                done_q   <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (fifo_wr),
    .wr_data_i  (adc_data_in),
    .rd_ready_i (ready_in),
    .data_o     (data_out),
    .valid_o    (valid_out),
    .level_o    (level_out),
    .drop_o     (fifo_drop)
  );

endmodule
